rotary_input_conditioner: RTL and testbench

Front-end conditioner for the rotary encoder panel: synchronises the raw encoder pins A and B and the pushbutton PB to `clk`, debounces each one, and decodes the quadrature sequence into single-cycle step pulses. It sits between the board pins and the rotational encoder counter stage. Its clean levels and step pulses replace direct pin sampling in that stage. It also provides pushbutton level and edge pulses for the press-duration counter.

---
 rtl/rotary_input_conditioner_if.sv | 33 +++
 rtl/rotary_input_conditioner.sv | 139 +++++++++++++
 tb/tb_rotary_input_conditioner.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/rotary_input_conditioner_if.sv
// Pin-side bundle for the rotary input conditioner.
//   A_raw, B_raw, PB_raw : raw asynchronous board pins (PB low = pressed)
//   A_clean, B_clean     : debounced encoder levels
//   pb_pressed           : debounced button state, high = pressed
//   cw_step, ccw_step    : one-cycle pulse per completed detent
//   pb_press, pb_release : one-cycle pulses on debounced button edges
//   quad_err             : one-cycle pulse on an illegal quadrature transition
// slave = conditioner side, master = pin driver / consumer side.
interface rotary_input_conditioner_if;
  logic A_raw;
  logic B_raw;
  logic PB_raw;
  logic A_clean;
  logic B_clean;
  logic pb_pressed;
  logic cw_step;
  logic ccw_step;
  logic pb_press;
  logic pb_release;
  logic quad_err;

  modport slave (
    input  A_raw, B_raw, PB_raw,
    output A_clean, B_clean, pb_pressed, cw_step, ccw_step,
           pb_press, pb_release, quad_err
  );

  modport master (
    output A_raw, B_raw, PB_raw,
    input  A_clean, B_clean, pb_pressed, cw_step, ccw_step,
           pb_press, pb_release, quad_err
  );
endinterface

// File: rtl/rotary_input_conditioner.sv
// Rotary encoder front end: 2-flop synchronisers, per-channel debouncers,
// quadrature decoder producing detent step pulses, and pushbutton edge pulses.
//   clk  : system clock, rising edge
//   rst  : asynchronous reset, active high
//   pins : rotary_input_conditioner_if.slave (raw pins in, clean levels/pulses out)
//
// Quadrature decoder states ({A_clean,B_clean} seen last cycle):
//   state | meaning
//   Q00   | detent rest position
//   Q10   | first quarter clockwise / last quarter counter-clockwise
//   Q11   | half way between detents
//   Q01   | last quarter clockwise / first quarter counter-clockwise
module rotary_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input logic                         clk,
  input logic                         rst,
  rotary_input_conditioner_if.slave   pins
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  // Channel order {PB, B, A}; PB idles high (released).
  localparam logic [2:0] IDLE = 3'b100;

  logic [2:0]    sync1, sync2, clean;
  logic [CW-1:0] cnt [3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= IDLE;
      sync2 <= IDLE;
    end else begin
      sync1 <= {pins.PB_raw, pins.B_raw, pins.A_raw};
      sync2 <= sync1;
    end
  end

  // A change is accepted on the cycle the count would reach DEBOUNCE_CYCLES,
  // so the counter never has to hold that value itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clean <= IDLE;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == clean[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          clean[i] <= sync2[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  typedef enum logic [1:0] {Q00 = 2'b00, Q01 = 2'b01, Q10 = 2'b10, Q11 = 2'b11} quad_t;

  quad_t             q_state, q_next;
  logic signed [2:0] acc, acc_next;
  logic [1:0]        ab, diff;
  logic              fwd, rev;
  logic              cw_next, ccw_next, err_next;
  logic              cw_q, ccw_q, err_q;
  logic              pb_prev, press_q, release_q;

  assign ab   = {clean[0], clean[1]};
  assign diff = ab ^ q_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_state <= Q00;
      acc     <= '0;
      cw_q    <= 1'b0;
      ccw_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      q_state <= q_next;
      acc     <= acc_next;
      cw_q    <= cw_next;
      ccw_q   <= ccw_next;
      err_q   <= err_next;
    end
  end

  // acc only ever spans -3..+3 while away from 00; the +-4 case is detected
  // as "a step from +-3 that lands on 00", which keeps acc at 3 bits.
  always_comb begin
    q_next   = quad_t'(ab);
    acc_next = acc;
    cw_next  = 1'b0;
    ccw_next = 1'b0;
    err_next = 1'b0;
    fwd      = 1'b0;
    rev      = 1'b0;
    unique case (q_state)
      Q00: begin fwd = (ab == 2'b10); rev = (ab == 2'b01); end
      Q10: begin fwd = (ab == 2'b11); rev = (ab == 2'b00); end
      Q11: begin fwd = (ab == 2'b01); rev = (ab == 2'b10); end
      Q01: begin fwd = (ab == 2'b00); rev = (ab == 2'b11); end
    endcase
    if (diff == 2'b11) begin
      err_next = 1'b1;
      acc_next = '0;
    end else if (fwd || rev) begin
      if (ab == 2'b00) begin
        cw_next  = fwd && (acc == 3'sd3);
        ccw_next = rev && (acc == -3'sd3);
        acc_next = '0;
      end else begin
        acc_next = fwd ? acc + 3'sd1 : acc - 3'sd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pb_prev   <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      pb_prev   <= clean[2];
      press_q   <= ~clean[2] & pb_prev;
      release_q <= clean[2] & ~pb_prev;
    end
  end

  assign pins.A_clean    = clean[0];
  assign pins.B_clean    = clean[1];
  assign pins.pb_pressed = ~clean[2];
  assign pins.cw_step    = cw_q;
  assign pins.ccw_step   = ccw_q;
  assign pins.quad_err   = err_q;
  assign pins.pb_press   = press_q;
  assign pins.pb_release = release_q;

endmodule

// File: tb/tb_rotary_input_conditioner.sv
module tb_rotary_input_conditioner;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rotary_input_conditioner_if pins();
  rotary_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (.clk(clk), .rst(rst), .pins(pins));

  int tests = 0;
  int fails = 0;
  int n_cw, n_ccw, n_err, n_press, n_rel, n_any;

  typedef struct {
    logic a, b, pb;
    int   hold;
    int   e_cw, e_ccw, e_err, e_press, e_rel;
    logic e_a, e_b, e_pbp;
  } vec_t;
  vec_t vecs[16];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    n_cw = 0; n_ccw = 0; n_err = 0; n_press = 0; n_rel = 0; n_any = 0;
  endtask

  // Advance one edge and sample 1ns later; counts cycles each pulse is high.
  task automatic tick();
    @(posedge clk);
    #1;
    n_cw    += int'(pins.cw_step);
    n_ccw   += int'(pins.ccw_step);
    n_err   += int'(pins.quad_err);
    n_press += int'(pins.pb_press);
    n_rel   += int'(pins.pb_release);
    if (pins.cw_step || pins.ccw_step || pins.quad_err || pins.pb_press ||
        pins.pb_release || pins.A_clean || pins.B_clean || pins.pb_pressed)
      n_any++;
  endtask

  task automatic drive(input logic a, input logic b, input logic pb, input int n);
    pins.A_raw = a; pins.B_raw = b; pins.PB_raw = pb;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Returns the edge count (1-based) at which the selected condition is first seen.
  task automatic edges_until(input int which, input int limit, output int n);
    logic hit;
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      case (which)
        0: hit = pins.A_clean;
        1: hit = pins.cw_step;
        2: hit = pins.pb_pressed;
        default: hit = pins.pb_press;
      endcase
      if (hit) begin n = i; break; end
    end
  endtask

  int n;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 20, 0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 20, 0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 20, 0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 20, 1, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 20, 0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 20, 0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 20, 0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 20, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 20, 0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 20, 0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 20, 0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 20, 0, 1, 0, 0, 0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 20, 0, 0, 1, 0, 0, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 20, 0, 0, 1, 0, 0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 40, 0, 0, 0, 1, 0, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 20, 0, 0, 0, 0, 1, 1'b0, 1'b0, 1'b0};

    // Reset state and quiet release.
    pins.A_raw = 1'b0; pins.B_raw = 1'b0; pins.PB_raw = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", int'({pins.A_clean, pins.B_clean, pins.pb_pressed, pins.cw_step,
                                 pins.ccw_step, pins.quad_err, pins.pb_press, pins.pb_release}), 0);
    rst = 1'b0;
    clear_counts();
    drive(1'b0, 1'b0, 1'b1, 50);
    check("reset_release_quiet", n_any, 0);

    // Table: CW detent, reversal, CCW detent, illegal jumps, button edges.
    for (int v = 0; v < 16; v++) begin
      clear_counts();
      drive(vecs[v].a, vecs[v].b, vecs[v].pb, vecs[v].hold);
      check($sformatf("v%0d_cw", v),      n_cw,    vecs[v].e_cw);
      check($sformatf("v%0d_ccw", v),     n_ccw,   vecs[v].e_ccw);
      check($sformatf("v%0d_err", v),     n_err,   vecs[v].e_err);
      check($sformatf("v%0d_press", v),   n_press, vecs[v].e_press);
      check($sformatf("v%0d_release", v), n_rel,   vecs[v].e_rel);
      check($sformatf("v%0d_A_clean", v), int'(pins.A_clean),    int'(vecs[v].e_a));
      check($sformatf("v%0d_B_clean", v), int'(pins.B_clean),    int'(vecs[v].e_b));
      check($sformatf("v%0d_pb_pressed", v), int'(pins.pb_pressed), int'(vecs[v].e_pbp));
    end

    // CW step latency: pulse D+3 edges after the final pin change to 00.
    drive(1'b1, 1'b0, 1'b1, 20);
    drive(1'b1, 1'b1, 1'b1, 20);
    drive(1'b0, 1'b1, 1'b1, 20);
    clear_counts();
    pins.A_raw = 1'b0; pins.B_raw = 1'b0;
    edges_until(1, 20, n);
    check("cw_latency", n, D + 3);
    drive(1'b0, 1'b0, 1'b1, 20);
    check("cw_latency_count", n_cw, 1);
    check("cw_latency_no_ccw", n_ccw + n_err, 0);

    // Bounce on A: toggles every 2 cycles, then settles high.
    clear_counts();
    begin
      int changes = 0;
      logic last = pins.A_clean;
      for (int s = 0; s < 14; s++) begin
        pins.A_raw = (s % 2 == 0);
        for (int c = 0; c < 2; c++) begin
          tick();
          if (pins.A_clean != last) begin changes++; last = pins.A_clean; end
        end
      end
      check("bounce_no_change", changes, 0);
      pins.A_raw = 1'b1;
      edges_until(0, 20, n);
      check("bounce_settle_latency", n, D + 2);
    end
    drive(1'b0, 1'b0, 1'b1, 20);
    check("bounce_no_step", n_cw + n_ccw + n_err, 0);

    // Short PB glitch is rejected.
    clear_counts();
    drive(1'b0, 1'b0, 1'b0, 3);
    drive(1'b0, 1'b0, 1'b1, 20);
    check("pb_glitch_pressed_cycles", n_any, 0);

    // Pushbutton press latency and pulse.
    clear_counts();
    pins.PB_raw = 1'b0;
    edges_until(2, 20, n);
    check("pb_press_latency", n, D + 2);
    drive(1'b0, 1'b0, 1'b0, 34);
    check("pb_press_count", n_press, 1);
    clear_counts();
    drive(1'b0, 1'b0, 1'b1, 20);
    check("pb_release_count", n_rel, 1);
    check("pb_released_level", int'(pins.pb_pressed), 0);

    // Mid-sequence asynchronous reset at state 11, then a full CW detent.
    drive(1'b1, 1'b0, 1'b1, 20);
    drive(1'b1, 1'b1, 1'b1, 20);
    check("pre_reset_state", int'({pins.A_clean, pins.B_clean}), 3);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_clear", int'({pins.A_clean, pins.B_clean, pins.pb_pressed, pins.cw_step,
                                     pins.ccw_step, pins.quad_err, pins.pb_press, pins.pb_release}), 0);
    pins.A_raw = 1'b0; pins.B_raw = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_counts();
    drive(1'b0, 1'b0, 1'b1, 10);
    drive(1'b1, 1'b0, 1'b1, 20);
    drive(1'b1, 1'b1, 1'b1, 20);
    drive(1'b0, 1'b1, 1'b1, 20);
    drive(1'b0, 1'b0, 1'b1, 20);
    check("post_reset_cw", n_cw, 1);
    check("post_reset_clean", n_ccw + n_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
